// File: rtl/bat_amateur_pkg.sv
// Shared sizes and register indices for the BAT amateur register file.
// Imported by the register file top and its output FIFO.
package bat_amateur_pkg;

    localparam int DATA_W         = 8;
    localparam int NUM_REGS       = 8;
    localparam int IDX_A          = 0;
    localparam int IDX_B          = 1;
    localparam int IDX_OUT        = 7;
    localparam int OUT_FIFO_DEPTH = 2;

    // Modulo-256 increment; 0xFF wraps to 0x00.
    function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
        return v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/bat_amateur_out_fifo.sv
// Output queue between the OUT register and the display sink.
// Ports: clk, rst (sync, active-high), push/push_data, pop_ready, head, valid, overflow.
module bat_amateur_out_fifo
    import bat_amateur_pkg::*;
#(
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int W     = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         overflow
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem   [DEPTH];
    logic [W-1:0]  mem_n [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          ovf;
    logic          ovf_n;
    logic          pop;

    assign pop = (cnt != '0) && pop_ready;

    // Pop is applied first, so a push into a full queue that pops in the
    // same cycle lands in the freed slot. Empty slots are kept at zero so
    // the head reads 0x00 when nothing is queued.
    always_comb begin
        mem_n = mem;
        cnt_n = cnt;
        ovf_n = ovf;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_n[i] = mem[i+1];
            end
            mem_n[DEPTH-1] = '0;
            cnt_n = cnt - CW'(1);
        end
        if (push) begin
            if (cnt_n < CW'(DEPTH)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == cnt_n) begin
                        mem_n[i] = push_data;
                    end
                end
                cnt_n = cnt_n + CW'(1);
            end else begin
                ovf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            mem <= mem_n;
            cnt <= cnt_n;
            ovf <= ovf_n;
        end
    end

    assign head     = mem[0];
    assign valid    = (cnt != '0);
    assign overflow = ovf;

endmodule

// File: rtl/bat_amateur_regfile.sv
// Eight 8-bit bus registers (A, B, R3..R7, OUT) with load/increment/drive,
// bus-conflict detection and a queued OUT stream to the display sink.
module bat_amateur_regfile
    import bat_amateur_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] BUS_IN,
    input  logic [NUM_REGS-1:0] REGS_INC,
    input  logic [NUM_REGS-1:0] REGS_RW,
    input  logic [NUM_REGS-1:0] REGS_EN,
    output logic [DATA_W-1:0] BUS_OUT,
    output logic              BUS_DRIVE,
    output logic              BUS_CONFLICT,
    output logic [DATA_W-1:0] REG_A,
    output logic [DATA_W-1:0] REG_B,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_OVERFLOW
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] load;
    logic [NUM_REGS-1:0] bump;
    logic [NUM_REGS-1:0] drv;
    logic                one_drv;
    logic                multi_drv;
    logic [DATA_W-1:0]   bus_mux;
    logic                conflict;
    logic                out_push;
    logic [DATA_W-1:0]   out_next;

    assign load = REGS_EN & REGS_RW;
    assign bump = REGS_INC & ~load;
    // Enables are ignored while reset is held.
    assign drv  = RST ? '0 : (REGS_EN & ~REGS_RW);

    // Clearing the lowest set bit leaves something only if 2+ bits are set.
    assign multi_drv = (drv & (drv - NUM_REGS'(1))) != '0;
    assign one_drv   = (drv != '0) && !multi_drv;

    always_comb begin
        bus_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (drv[i]) begin
                bus_mux = bus_mux | regs[i];
            end
        end
    end

    assign BUS_OUT   = one_drv ? bus_mux : '0;
    assign BUS_DRIVE = one_drv;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            conflict <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load[i]) begin
                    regs[i] <= BUS_IN;
                end else if (bump[i]) begin
                    regs[i] <= inc_wrap(regs[i]);
                end
            end
            if (multi_drv) begin
                conflict <= 1'b1;
            end
        end
    end

    assign BUS_CONFLICT = conflict;
    assign REG_A        = regs[IDX_A];
    assign REG_B        = regs[IDX_B];

    // The queue receives the value OUT will hold after this edge.
    assign out_push = !RST && (load[IDX_OUT] || bump[IDX_OUT]);
    assign out_next = load[IDX_OUT] ? BUS_IN : inc_wrap(regs[IDX_OUT]);

    bat_amateur_out_fifo u_out_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (out_push),
        .push_data (out_next),
        .pop_ready (OUT_READY),
        .head      (OUT_DATA),
        .valid     (OUT_VALID),
        .overflow  (OUT_OVERFLOW)
    );

endmodule
